// File: rtl/logo_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logo_ram_pkg
// Brief    : Shared widths and grant-owner enumeration for the logo RAM arbiter
// Revision : 1.0 - initial release
// ============================================================================
package logo_ram_pkg;

  localparam int unsigned c_addr_w_def     = 14;
  localparam int unsigned c_data_w_def     = 8;
  localparam int unsigned c_starve_max_def = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    LDR  = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/logo_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : logo_ram_arbiter_if
// Brief    : CPU, loader and RAM-side signals of the logo RAM arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface logo_ram_arbiter_if
  import logo_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = c_addr_w_def,
  parameter int unsigned DATA_W = c_data_w_def
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_done;

  logic              locked;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_done,
    output ldr_ack, ldr_rvalid, ldr_rdata,
    output locked, ram_address, ram_data, ram_wren,
    input  ram_q
  );

  // Requesters and RAM side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_done,
    input  ldr_ack, ldr_rvalid, ldr_rdata,
    input  locked, ram_address, ram_data, ram_wren,
    output ram_q
  );

endinterface
`default_nettype wire

// File: rtl/logo_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logo_ram_arbiter
// Brief    : Two-port (CPU/loader) arbiter for a single-port logo RAM with
//            loader anti-starvation and a sticky write-protect after load.
// Revision : 1.0 - initial release
// ============================================================================
module logo_ram_arbiter
  import logo_ram_pkg::*;
#(
  parameter int unsigned ADDR_W     = c_addr_w_def,
  parameter int unsigned DATA_W     = c_data_w_def,
  parameter int unsigned STARVE_MAX = c_starve_max_def
) (
  input  logic               clock,
  input  logic               reset_n,
  logo_ram_arbiter_if.slave  bus
);

  localparam int unsigned      CNT_W        = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

  owner_t            w_owner;
  logic              w_owner_we;
  logic [ADDR_W-1:0] w_owner_addr;
  logic [DATA_W-1:0] w_owner_wdata;

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_locked;
  logic              r_cpu_rvalid;
  logic              r_ldr_rvalid;
  logic [ADDR_W-1:0] r_last_addr;

  // Grant is gated by reset_n so nothing reaches the RAM while reset is held.
  always_comb begin
    w_owner = NONE;
    if (reset_n) begin
      if (bus.cpu_req && bus.ldr_req) begin
        if (r_starve_cnt == c_starve_max) begin
          w_owner = LDR;
        end else begin
          w_owner = CPU;
        end
      end else if (bus.cpu_req) begin
        w_owner = CPU;
      end else if (bus.ldr_req) begin
        w_owner = LDR;
      end
    end
  end

  always_comb begin
    w_owner_we    = 1'b0;
    w_owner_addr  = r_last_addr;
    w_owner_wdata = '0;
    case (w_owner)
      CPU: begin
        w_owner_we    = bus.cpu_we;
        w_owner_addr  = bus.cpu_addr;
        w_owner_wdata = bus.cpu_wdata;
      end
      LDR: begin
        w_owner_we    = bus.ldr_we;
        w_owner_addr  = bus.ldr_addr;
        w_owner_wdata = bus.ldr_wdata;
      end
      default: ;
    endcase
  end

  assign bus.cpu_ack     = (w_owner == CPU);
  assign bus.ldr_ack     = (w_owner == LDR);
  assign bus.ram_address = w_owner_addr;
  assign bus.ram_data    = w_owner_wdata;
  assign bus.ram_wren    = w_owner_we && !r_locked;
  assign bus.locked      = r_locked;

  // The RAM registers its output, so both ports simply see ram_q.
  assign bus.cpu_rvalid  = r_cpu_rvalid;
  assign bus.ldr_rvalid  = r_ldr_rvalid;
  assign bus.cpu_rdata   = bus.ram_q;
  assign bus.ldr_rdata   = bus.ram_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      r_last_addr  <= '0;
    end else begin
      r_cpu_rvalid <= (w_owner == CPU) && !bus.cpu_we;
      r_ldr_rvalid <= (w_owner == LDR) && !bus.ldr_we;
      if (w_owner != NONE) begin
        r_last_addr <= w_owner_addr;
      end
    end
  end

  // Counts consecutive cycles the loader waits; a dropped request forgets history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.ldr_req || (w_owner == LDR)) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != c_starve_max) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_locked <= 1'b0;
    end else if (bus.ldr_done) begin
      r_locked <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logo_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logo_ram_arbiter
// Brief    : Scoreboard bench for logo_ram_arbiter with a behavioural RAM model
// Revision : 1.0 - initial release
// ============================================================================
module tb_logo_ram_arbiter;
  import logo_ram_pkg::*;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int SM = 4;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } port_t;

  typedef struct packed {
    logic          cpu_ack;
    logic          ldr_ack;
    logic          wren;
    logic          locked;
    logic          chk_data;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct packed {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logo_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logo_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Environment RAM: single port, registered read
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.ram_wren) ram[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= ram[bus.ram_address];
  end

  // Reference model state
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  bit            mdl_locked = 1'b0;
  int            mdl_wait   = 0;
  logic [AW-1:0] mdl_last_addr = '0;

  exp_t grant_q [$];
  rd_t  cpu_rd_q [$];
  rd_t  ldr_rd_q [$];

  int cycle_no = 0;
  int n_checks = 0;
  int n_pass   = 0;

  always @(posedge clock) cycle_no++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle_no);
  endtask

  function automatic port_t mk(input bit req, input bit we, input int addr, input int data);
    port_t p;
    p.req  = req;
    p.we   = we;
    p.addr = AW'(addr);
    p.data = DW'(data);
    return p;
  endfunction

  // One bus cycle: drive inputs, predict the response, queue the expectation.
  // rst_mode: 0 none, 1 reset held all cycle, 2 reset pulsed after the grant.
  task automatic cycle(input port_t c, input port_t l, input bit done,
                       input int rst_mode, output owner_t own);
    exp_t  e;
    port_t p;
    owner_t o;
    @(posedge clock);
    #1;
    reset_n       = (rst_mode != 1);
    bus.cpu_req   = c.req;
    bus.cpu_we    = c.we;
    bus.cpu_addr  = c.addr;
    bus.cpu_wdata = c.data;
    bus.ldr_req   = l.req;
    bus.ldr_we    = l.we;
    bus.ldr_addr  = l.addr;
    bus.ldr_wdata = l.data;
    bus.ldr_done  = done;
    e = '0;
    o = NONE;
    if (rst_mode != 0) begin
      mdl_locked    = 1'b0;
      mdl_wait      = 0;
      mdl_last_addr = '0;
      cpu_rd_q.delete();
      ldr_rd_q.delete();
    end else begin
      if (c.req && l.req) o = (mdl_wait >= SM) ? LDR : CPU;
      else if (c.req)     o = CPU;
      else if (l.req)     o = LDR;
      e.locked  = mdl_locked;
      e.cpu_ack = (o == CPU);
      e.ldr_ack = (o == LDR);
      if (o != NONE) begin
        p = (o == CPU) ? c : l;
        e.chk_data = 1'b1;
        e.addr     = p.addr;
        e.data     = p.data;
        e.wren     = p.we && !mdl_locked;
        if (p.we && !mdl_locked) mdl_mem[p.addr] = p.data;
        if (!p.we) begin
          if (o == CPU) cpu_rd_q.push_back('{cycle_no + 1, mdl_mem[p.addr]});
          else          ldr_rd_q.push_back('{cycle_no + 1, mdl_mem[p.addr]});
        end
        mdl_last_addr = p.addr;
      end else begin
        e.addr = mdl_last_addr;
      end
      if (l.req && o != LDR) mdl_wait = (mdl_wait < SM) ? mdl_wait + 1 : SM;
      else                   mdl_wait = 0;
      if (done) mdl_locked = 1'b1;
    end
    e.addr = (rst_mode != 0) ? '0 : e.addr;
    grant_q.push_back(e);
    if (rst_mode == 2) begin
      #2;
      reset_n = 1'b0;
    end
    own = o;
  endtask

  function automatic port_t rand_port();
    bit we;
    we = ($urandom_range(0, 1) == 1);
    // Writes stay in 0x80..0xFF so the directed image in 0x00..0x3F survives
    if (we) return mk(1, 1, 'h80 + $urandom_range(0, 127), $urandom_range(0, 255));
    else    return mk(1, 0, $urandom_range(0, 255), 0);
  endfunction

  task automatic run_random(input int n);
    port_t  c = '0;
    port_t  l = '0;
    owner_t o;
    repeat (n) begin
      if (!c.req && $urandom_range(0, 2) != 0)      c = rand_port();
      else if (c.req && $urandom_range(0, 15) == 0) c.req = 1'b0;
      if (!l.req && $urandom_range(0, 2) != 0)      l = rand_port();
      else if (l.req && $urandom_range(0, 15) == 0) l.req = 1'b0;
      cycle(c, l, 0, 0, o);
      if (o == CPU) c.req = 1'b0;
      if (o == LDR) l.req = 1'b0;
    end
  endtask

  // Both ports requesting without pause; loader writes above the image area
  task automatic run_contention(input int n, input int rd_addr);
    port_t  l;
    owner_t o;
    int     k = 0;
    repeat (n) begin
      l = mk(1, 1, 'h100 + k, k);
      cycle(mk(1, 0, rd_addr, 0), l, 0, 0, o);
      if (o == LDR) k++;
    end
  endtask

  // Monitor: per-cycle grant checks and latency-tagged read-data checks
  exp_t e_mon;
  bit   exp_cv, exp_lv;
  always @(negedge clock) begin
    if (grant_q.size() > 0) begin
      e_mon = grant_q.pop_front();
      check("cpu_ack",     bus.cpu_ack,     e_mon.cpu_ack);
      check("ldr_ack",     bus.ldr_ack,     e_mon.ldr_ack);
      check("ram_wren",    bus.ram_wren,    e_mon.wren);
      check("ram_address", bus.ram_address, e_mon.addr);
      check("locked",      bus.locked,      e_mon.locked);
      if (e_mon.chk_data) check("ram_data", bus.ram_data, e_mon.data);
    end
    exp_cv = (cpu_rd_q.size() > 0) && (cpu_rd_q[0].due == cycle_no);
    check("cpu_rvalid", bus.cpu_rvalid, exp_cv);
    if (exp_cv) begin
      check("cpu_rdata", bus.cpu_rdata, cpu_rd_q[0].data);
      void'(cpu_rd_q.pop_front());
    end
    exp_lv = (ldr_rd_q.size() > 0) && (ldr_rd_q[0].due == cycle_no);
    check("ldr_rvalid", bus.ldr_rvalid, exp_lv);
    if (exp_lv) begin
      check("ldr_rdata", bus.ldr_rdata, ldr_rd_q[0].data);
      void'(ldr_rd_q.pop_front());
    end
  end

  initial begin
    port_t  idle;
    owner_t o;
    idle = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    bus.ldr_done = 0;

    repeat (3) cycle(idle, idle, 0, 1, o);

    // Image load 0x00..0x3F, one write per cycle, then CPU reads 0x10
    for (int i = 0; i < 64; i++) cycle(idle, mk(1, 1, i, i), 0, 0, o);
    cycle(mk(1, 0, 'h10, 0), idle, 0, 0, o);
    cycle(idle, idle, 0, 0, o);

    run_contention(20, 'h05);

    // Loader drops its request mid-wait, so its starve history is lost
    repeat (3) cycle(mk(1, 0, 'h01, 0), mk(1, 1, 'h120, 1), 0, 0, o);
    cycle(mk(1, 0, 'h02, 0), idle, 0, 0, o);
    run_contention(10, 'h03);

    run_random(150);

    // Loader write coinciding with ldr_done, then protection checks
    cycle(idle, mk(1, 1, 'h3FFF, 'h7E), 1, 0, o);
    cycle(mk(1, 0, 'h3FFF, 0), idle, 0, 0, o);
    cycle(idle, mk(1, 1, 'h3FFF, 'h11), 0, 0, o);
    cycle(mk(1, 0, 'h3FFF, 0), idle, 0, 0, o);
    cycle(mk(1, 1, 'h10, 'hA5), idle, 0, 0, o);
    cycle(mk(1, 0, 'h10, 0), idle, 0, 0, o);
    cycle(idle, idle, 0, 0, o);

    run_random(150);

    // Read of 0x20 granted, reset pulsed in the same cycle
    cycle(mk(1, 0, 'h20, 0), idle, 0, 2, o);
    run_contention(10, 'h20);
    cycle(mk(1, 0, 'h20, 0), idle, 0, 0, o);

    run_random(100);
    repeat (3) cycle(idle, idle, 0, 0, o);

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
